reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//   Circular in-order commit queue between decoder dispatch and register_file retirement.
//   - Allocates one entry per dispatched instruction at rob_tail_id.
//   - Captures ALU/LSB write-back results.
//   - Retires the head entry to register_file through rob_ready/rob_rd/rob_val.
//   - Raises a one-cycle flush after a mispredicted control instruction retires.
// PARAMETERS (global_params.v macros)
//   ROB_SIZE_WIDTH   3   log2 entry count (8 entries); ids wrap modulo 2^ROB_SIZE_WIDTH
//   XLEN             32  data/pc width
//   REG_CNT_WIDTH    5   architectural register index width
//   INST_TYPE_WIDTH  6   decoded op width (`BEQ..`BGEU, `SB/`SH/`SW, `JALR, ...)
// PORTS
//   clk            in   1     clock, rising edge
//   rst            in   1     asynchronous active-high reset
//   stall          in   1     global stall; dispatch blocked while high
//   dec_ready      in   1     decoder presents an instruction
//   dec_op         in   INST_TYPE_WIDTH   decoded op
//   dec_rd         in   REG_CNT_WIDTH     destination register
//   dec_pc         in   XLEN  instruction pc
//   dec_pred_jump  in   1     predictor decision (taken) for branches/JALR
//   alu_ready      in   1     ALU write-back valid
//   alu_rob_id     in   ROB_SIZE_WIDTH    target entry
//   alu_val        in   XLEN  result (link value for JALR)
//   alu_jump       in   1     actual taken outcome
//   alu_target     in   XLEN  actual next pc
//   lsb_ready      in   1     LSB write-back valid
//   lsb_rob_id     in   ROB_SIZE_WIDTH    target entry
//   lsb_val        in   XLEN  load data (don't-care for stores)
//   qry1_id, qry2_id  in   ROB_SIZE_WIDTH each   operand dependency lookup
//   qry1_done, qry2_done  out  1 each   queried entry busy and result available
//   qry1_val, qry2_val    out  XLEN each   queried entry result
//   rob_ready      out  1     one-cycle retire pulse to register_file
//   rob_rd         out  REG_CNT_WIDTH     retired rd; 0 for branches/stores
//   rob_val        out  XLEN  retired value
//   rob_head_id    out  ROB_SIZE_WIDTH    oldest live entry id (registered)
//   rob_tail_id    out  ROB_SIZE_WIDTH    id for next dispatch (registered)
//   rob_full       out  1     count == 2^ROB_SIZE_WIDTH (combinational from count)
//   rob_flush      out  1     one-cycle pipeline flush
//   rob_flush_pc   out  XLEN  redirect pc, valid while rob_flush
// BEHAVIOUR
//   Reset (async)
//     head = tail = count = 0; all busy = done = 0; state = RUN.
//     rob_ready, rob_rd, rob_val, rob_flush, rob_flush_pc all 0.
//   Dispatch
//     Occurs when dec_ready && !stall && !rob_full && state == RUN.
//     Entry[tail] <= {busy=1, done=0, rd, pc, op, pred_jump}; tail++ with wrap.
//     Stores and branches record rd = 0.
//     Dispatch while full is ignored (protocol violation).
//   Write-back
//     Writes to a busy entry only: done=1, val; jump and target are latched from the ALU.
//     If alu_rob_id == lsb_rob_id in the same cycle, the ALU wins.
//     Write-back to a non-busy id is ignored.
//   Commit
//     Fires in RUN when entry[head] is busy && done.
//     Same edge: rob_ready <= 1, rob_rd <= rd, rob_val <= val, busy <= 0, head++, count--.
//     So rob_head_id = committed id + 1 while rob_ready is high.
//     Register_file depends on this relation.
//     At most one commit per cycle.
//     An entry written back in cycle N commits at the earliest at edge N+1.
//   Misprediction
//     Branch: alu_jump != pred_jump. JALR: always treated as mispredicted.
//     Committing such an entry retires it normally, latches flush_pc = alu_target, state -> FLUSH.
//   FLUSH state (one cycle)
//     No commit, no dispatch.
//     Next edge: rob_flush <= 1, rob_flush_pc valid; all busy = 0; head = tail = count = 0; state -> RUN.
//     rob_flush is never high in the same cycle as rob_ready, so the rd write is not dropped.
//   Dispatch and commit in the same cycle
//     count unchanged.
//     rob_full is evaluated before the edge, so no dispatch when full even if committing.
//   Queries
//     Combinational: qryN_done = busy[id] && done[id]; qryN_val = val[id].
//   Reset mid-operation
//     Everything clears immediately, including a pending FLUSH.
// CONFIGURATION
//   ROB_CDB_BYPASS_EN defined
//     Queries also match same-cycle write-back.
//     If alu_ready && alu_rob_id == qryN_id (entry busy): qryN_done = 1, qryN_val = alu_val.
//     Same for LSB; ALU has priority.
//   ROB_CDB_BYPASS_EN undefined
//     Queries see stored entries only; the result is visible one cycle after write-back.
// TESTING
//   1. Reset, then dispatch 3 ALU ops (rd = 1, 2, 3); write back ids 2, 0, 1 with 0x11, 0x22, 0x33.
//      -> rob_ready pulses retire rd 1, 2, 3 in order with 0x22, 0x33, 0x11; rob_head_id = 1, 2, 3.
//   2. Dispatch 8 entries with no write-back.
//      -> rob_full = 1, rob_tail_id = 0; a 9th dec_ready is ignored; count stays 8.
//   3. Full ROB, head done, dec_ready held.
//      -> commit at edge, no dispatch that cycle; dispatch accepted next cycle; tail wraps 0 -> 1.
//   4. BEQ pred = 0, alu_jump = 1, target 0x1000, commits.
//      -> rob_ready = 1, rd = 0; one cycle later rob_flush = 1, pc 0x1000; head = tail = 0; rob_full = 0.
//   5. qry1_id = 4 while alu_ready writes id 4 with 0xABCD.
//      -> qry1_done = 1, qry1_val = 0xABCD same cycle if ROB_CDB_BYPASS_EN, else next cycle.
//   6. Assert rst during the FLUSH state.
//      -> all outputs 0 immediately; no rob_flush pulse after release.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: dispatch at tail, ALU/LSB write-back, in-order retire and
// one-cycle flush after a mispredicted branch/JALR retires. Optional macro: ROB_CDB_BYPASS_EN.
module reorder_buffer #(
  parameter int ROB_SIZE_WIDTH  = 3,
  parameter int XLEN            = 32,
  parameter int REG_CNT_WIDTH   = 5,
  parameter int INST_TYPE_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       dec_ready,
  input  logic [INST_TYPE_WIDTH-1:0] dec_op,
  input  logic [REG_CNT_WIDTH-1:0]   dec_rd,
  input  logic [XLEN-1:0]            dec_pc,
  input  logic                       dec_pred_jump,
  input  logic                       alu_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]  alu_rob_id,
  input  logic [XLEN-1:0]            alu_val,
  input  logic                       alu_jump,
  input  logic [XLEN-1:0]            alu_target,
  input  logic                       lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]  lsb_rob_id,
  input  logic [XLEN-1:0]            lsb_val,
  input  logic [ROB_SIZE_WIDTH-1:0]  qry1_id,
  input  logic [ROB_SIZE_WIDTH-1:0]  qry2_id,
  output logic                       qry1_done,
  output logic                       qry2_done,
  output logic [XLEN-1:0]            qry1_val,
  output logic [XLEN-1:0]            qry2_val,
  output logic                       rob_ready,
  output logic [REG_CNT_WIDTH-1:0]   rob_rd,
  output logic [XLEN-1:0]            rob_val,
  output logic [ROB_SIZE_WIDTH-1:0]  rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0]  rob_tail_id,
  output logic                       rob_full,
  output logic                       rob_flush,
  output logic [XLEN-1:0]            rob_flush_pc
);

  localparam int DEPTH = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0] FULL_CNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

  // Decoded op encoding shared with the decoder.
  localparam logic [INST_TYPE_WIDTH-1:0] OP_BEQ  = INST_TYPE_WIDTH'(1);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_BGEU = INST_TYPE_WIDTH'(6);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_SB   = INST_TYPE_WIDTH'(7);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_SW   = INST_TYPE_WIDTH'(9);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_JALR = INST_TYPE_WIDTH'(10);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                      r_state, w_state_nxt;
  logic [ROB_SIZE_WIDTH-1:0]   r_head, r_tail;
  logic [ROB_SIZE_WIDTH:0]     r_count;
  logic [DEPTH-1:0]            r_busy, r_done;

  logic [REG_CNT_WIDTH-1:0]    r_rd     [DEPTH];
  logic [XLEN-1:0]             r_val    [DEPTH];
  logic [XLEN-1:0]             r_target [DEPTH];
  logic [DEPTH-1:0]            r_is_br, r_is_jalr, r_pred, r_jump;

  logic w_full, w_commit, w_dispatch, w_mispredict;
  logic w_alu_wb, w_lsb_wb, w_dec_is_br, w_dec_is_st;
  logic w_unused_pc;

  // The pc is not needed for retirement; the redirect comes from the ALU target.
  assign w_unused_pc = ^dec_pc;

  assign w_full      = (r_count == FULL_CNT);
  assign rob_full    = w_full;
  assign rob_head_id = r_head;
  assign rob_tail_id = r_tail;

  assign w_dec_is_br = (dec_op >= OP_BEQ) && (dec_op <= OP_BGEU);
  assign w_dec_is_st = (dec_op >= OP_SB)  && (dec_op <= OP_SW);

  assign w_alu_wb = alu_ready && r_busy[alu_rob_id];
  assign w_lsb_wb = lsb_ready && r_busy[lsb_rob_id] && !(alu_ready && (alu_rob_id == lsb_rob_id));

  assign w_mispredict = r_is_jalr[r_head] || (r_is_br[r_head] && (r_jump[r_head] != r_pred[r_head]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_commit && w_mispredict) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_commit   = 1'b0;
    w_dispatch = 1'b0;
    if (r_state == ST_RUN) begin
      w_commit   = r_busy[r_head] && r_done[r_head];
      w_dispatch = dec_ready && !stall && !w_full;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_busy       <= '0;
      r_done       <= '0;
      rob_ready    <= 1'b0;
      rob_rd       <= '0;
      rob_val      <= '0;
      rob_flush    <= 1'b0;
      rob_flush_pc <= '0;
    end else begin
      rob_ready <= 1'b0;
      rob_flush <= 1'b0;
      if (w_alu_wb) r_done[alu_rob_id] <= 1'b1;
      if (w_lsb_wb) r_done[lsb_rob_id] <= 1'b1;
      if (w_commit) begin
        rob_ready      <= 1'b1;
        rob_rd         <= r_rd[r_head];
        rob_val        <= r_val[r_head];
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
        if (w_mispredict) rob_flush_pc <= r_target[r_head];
      end
      if (w_dispatch) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      case ({w_dispatch, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // FLUSH cycle: commit and dispatch are already blocked, so this wipes the queue.
      if (r_state == ST_FLUSH) begin
        rob_flush <= 1'b1;
        r_busy    <= '0;
        r_done    <= '0;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alu_wb) begin
      r_val[alu_rob_id]    <= alu_val;
      r_jump[alu_rob_id]   <= alu_jump;
      r_target[alu_rob_id] <= alu_target;
    end
    if (w_lsb_wb) r_val[lsb_rob_id] <= lsb_val;
    if (w_dispatch) begin
      r_rd[r_tail]      <= (w_dec_is_br || w_dec_is_st) ? '0 : dec_rd;
      r_is_br[r_tail]   <= w_dec_is_br;
      r_is_jalr[r_tail] <= (dec_op == OP_JALR);
      r_pred[r_tail]    <= dec_pred_jump;
    end
  end

  always_comb begin
    qry1_done = r_busy[qry1_id] && r_done[qry1_id];
    qry1_val  = r_val[qry1_id];
    qry2_done = r_busy[qry2_id] && r_done[qry2_id];
    qry2_val  = r_val[qry2_id];
`ifdef ROB_CDB_BYPASS_EN
    // Same-cycle result forwarding; ALU checked last so it takes priority.
    if (w_lsb_wb && (lsb_rob_id == qry1_id)) begin qry1_done = 1'b1; qry1_val = lsb_val; end
    if (w_alu_wb && (alu_rob_id == qry1_id)) begin qry1_done = 1'b1; qry1_val = alu_val; end
    if (w_lsb_wb && (lsb_rob_id == qry2_id)) begin qry2_done = 1'b1; qry2_val = lsb_val; end
    if (w_alu_wb && (alu_rob_id == qry2_id)) begin qry2_done = 1'b1; qry2_val = alu_val; end
`else
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: retire order, full handling, flush,
// query timing (with or without ROB_CDB_BYPASS_EN) and reset during FLUSH.
module tb_reorder_buffer;

  localparam logic [5:0] OP_BEQ  = 6'd1;
  localparam logic [5:0] OP_JALR = 6'd10;
  localparam logic [5:0] OP_ADD  = 6'd20;

  logic        clk = 1'b0;
  logic        rst, stall, dec_ready, dec_pred_jump;
  logic [5:0]  dec_op;
  logic [4:0]  dec_rd;
  logic [31:0] dec_pc;
  logic        alu_ready, alu_jump, lsb_ready;
  logic [2:0]  alu_rob_id, lsb_rob_id, qry1_id, qry2_id;
  logic [31:0] alu_val, alu_target, lsb_val;
  logic        qry1_done, qry2_done, rob_ready, rob_full, rob_flush;
  logic [31:0] qry1_val, qry2_val, rob_val, rob_flush_pc;
  logic [4:0]  rob_rd;
  logic [2:0]  rob_head_id, rob_tail_id;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd), .dec_pc(dec_pc),
    .dec_pred_jump(dec_pred_jump),
    .alu_ready(alu_ready), .alu_rob_id(alu_rob_id), .alu_val(alu_val),
    .alu_jump(alu_jump), .alu_target(alu_target),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val),
    .qry1_id(qry1_id), .qry2_id(qry2_id),
    .qry1_done(qry1_done), .qry2_done(qry2_done),
    .qry1_val(qry1_val), .qry2_val(qry2_val),
    .rob_ready(rob_ready), .rob_rd(rob_rd), .rob_val(rob_val),
    .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
    .rob_full(rob_full), .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [4:0] rd, input logic pred);
    dec_op = op; dec_rd = rd; dec_pc = 32'h100; dec_pred_jump = pred; dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic alu_wb(input logic [2:0] id, input logic [31:0] v, input logic j, input logic [31:0] t);
    alu_ready = 1'b1; alu_rob_id = id; alu_val = v; alu_jump = j; alu_target = t;
    tick();
    alu_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; dec_ready = 1'b0; dec_op = '0; dec_rd = '0; dec_pc = '0;
    dec_pred_jump = 1'b0; alu_ready = 1'b0; alu_rob_id = '0; alu_val = '0; alu_jump = 1'b0;
    alu_target = '0; lsb_ready = 1'b0; lsb_rob_id = '0; lsb_val = '0; qry1_id = '0; qry2_id = '0;
    tick(); tick();
    check_eq("rst_ready", rob_ready, 0);
    check_eq("rst_head", rob_head_id, 0);
    check_eq("rst_tail", rob_tail_id, 0);
    check_eq("rst_full", rob_full, 0);
    check_eq("rst_flush", rob_flush, 0);
    check_eq("rst_flush_pc", rob_flush_pc, 0);
    check_eq("rst_rd_val", {rob_rd, rob_val}, 0);
    rst = 1'b0;

    // In-order retire of out-of-order write-backs
    dispatch(OP_ADD, 5'd1, 1'b0);
    dispatch(OP_ADD, 5'd2, 1'b0);
    dispatch(OP_ADD, 5'd3, 1'b0);
    check_eq("t1_tail", rob_tail_id, 3);
    alu_wb(3'd2, 32'h11, 1'b0, 32'h0);
    check_eq("t1_no_commit_a", rob_ready, 0);
    alu_wb(3'd0, 32'h22, 1'b0, 32'h0);
    check_eq("t1_no_commit_b", rob_ready, 0);
    alu_wb(3'd1, 32'h33, 1'b0, 32'h0);
    check_eq("t1_c0", {rob_ready, rob_rd, rob_val, rob_head_id}, {1'b1, 5'd1, 32'h22, 3'd1});
    tick();
    check_eq("t1_c1", {rob_ready, rob_rd, rob_val, rob_head_id}, {1'b1, 5'd2, 32'h33, 3'd2});
    tick();
    check_eq("t1_c2", {rob_ready, rob_rd, rob_val, rob_head_id}, {1'b1, 5'd3, 32'h11, 3'd3});
    tick();
    check_eq("t1_idle", rob_ready, 0);

    // Fill to capacity, then an ignored 9th dispatch
    do_reset();
    for (int i = 0; i < 8; i++) dispatch(OP_ADD, 5'(8 + i), 1'b0);
    check_eq("t2_full", rob_full, 1);
    check_eq("t2_tail", rob_tail_id, 0);
    dispatch(OP_ADD, 5'd31, 1'b0);
    check_eq("t2_ninth_tail", rob_tail_id, 0);
    check_eq("t2_ninth_full", {rob_full, rob_head_id}, {1'b1, 3'd0});

    // Commit while full with dec_ready held: dispatch only on the following edge
    dec_op = OP_ADD; dec_rd = 5'd20; dec_ready = 1'b1;
    alu_wb(3'd0, 32'h55, 1'b0, 32'h0);
    check_eq("t3_wb_full", {rob_full, rob_tail_id}, {1'b1, 3'd0});
    tick();
    check_eq("t3_commit", {rob_ready, rob_rd, rob_val, rob_head_id, rob_tail_id, rob_full},
             {1'b1, 5'd8, 32'h55, 3'd1, 3'd0, 1'b0});
    tick();
    check_eq("t3_dispatch", {rob_ready, rob_tail_id, rob_full}, {1'b0, 3'd1, 1'b1});
    dec_ready = 1'b0;

    // Mispredicted BEQ retires, then one-cycle flush
    do_reset();
    dispatch(OP_BEQ, 5'd7, 1'b0);
    dispatch(OP_ADD, 5'd4, 1'b0);
    alu_wb(3'd0, 32'h0, 1'b1, 32'h1000);
    tick();
    check_eq("t4_retire", {rob_ready, rob_rd, rob_flush, rob_head_id}, {1'b1, 5'd0, 1'b0, 3'd1});
    tick();
    check_eq("t4_flush", {rob_flush, rob_ready}, {1'b1, 1'b0});
    check_eq("t4_flush_pc", rob_flush_pc, 32'h1000);
    check_eq("t4_ptrs", {rob_head_id, rob_tail_id, rob_full}, {3'd0, 3'd0, 1'b0});
    tick();
    check_eq("t4_flush_end", rob_flush, 0);

    // Query timing, ALU-over-LSB priority, write-back to free entry
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(OP_ADD, 5'(i + 1), 1'b0);
    qry1_id = 3'd4; qry2_id = 3'd3;
    alu_ready = 1'b1; alu_rob_id = 3'd4; alu_val = 32'hABCD; alu_jump = 1'b0;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check_eq("t5_same_cycle", {qry1_done, qry1_val}, {1'b1, 32'hABCD});
`else
    check_eq("t5_same_cycle", qry1_done, 0);
`endif
    check_eq("t5_other", qry2_done, 0);
    tick();
    alu_ready = 1'b0;
    check_eq("t5_next_cycle", {qry1_done, qry1_val}, {1'b1, 32'hABCD});
    alu_ready = 1'b1; alu_rob_id = 3'd3; alu_val = 32'h77;
    lsb_ready = 1'b1; lsb_rob_id = 3'd3; lsb_val = 32'h99;
    tick();
    alu_ready = 1'b0; lsb_ready = 1'b0;
    check_eq("t5_alu_prio", {qry2_done, qry2_val}, {1'b1, 32'h77});
    qry2_id = 3'd6; lsb_ready = 1'b1; lsb_rob_id = 3'd6; lsb_val = 32'h5;
    tick();
    lsb_ready = 1'b0;
    check_eq("t5_free_wb", qry2_done, 0);

    // Reset asserted during the FLUSH cycle
    do_reset();
    dispatch(OP_JALR, 5'd5, 1'b0);
    alu_wb(3'd0, 32'h44, 1'b1, 32'h2000);
    tick();
    check_eq("t6_retire", {rob_ready, rob_rd, rob_val}, {1'b1, 5'd5, 32'h44});
    rst = 1'b1;
    #1;
    check_eq("t6_async_clear", {rob_ready, rob_rd, rob_val, rob_flush, rob_flush_pc, rob_head_id},
             {1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 3'd0});
    tick();
    rst = 1'b0;
    tick();
    check_eq("t6_no_flush_a", rob_flush, 0);
    tick();
    check_eq("t6_no_flush_b", {rob_flush, rob_head_id, rob_tail_id}, {1'b0, 3'd0, 3'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
